// File: rtl/flex_udc_counter_if.sv
// flex_udc_counter_if: control and status bundle for flex_udc_counter.
// The master side (the user of the counter) drives the controls and reads the
// count and flags; the slave side is the counter itself.
// There is no valid/ready handshake on this bundle: every control is a level
// sampled on each rising clock edge, and every status output is valid from
// the edge that produced it until the next edge.
interface flex_udc_counter_if #(
  parameter int NUM_CNT_BITS = 8
);
  logic                    clear;
  logic                    load;
  logic [NUM_CNT_BITS-1:0] load_val;
  logic                    count_enable;
  logic                    up_dn;
  logic                    sat_mode;
  logic [NUM_CNT_BITS-1:0] rollover_val;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    wrap_flag;
  logic                    sat_flag;
  logic                    at_max;
  logic                    at_min;

  modport master (
    output clear, load, load_val, count_enable, up_dn, sat_mode, rollover_val,
    input  count_out, wrap_flag, sat_flag, at_max, at_min
  );

  modport slave (
    input  clear, load, load_val, count_enable, up_dn, sat_mode, rollover_val,
    output count_out, wrap_flag, sat_flag, at_max, at_min
  );
endinterface

// File: rtl/flex_udc_counter.sv
// flex_udc_counter: up/down counter over the range 0..rollover_val with
// synchronous clear/load and registered one-cycle wrap/saturate pulses.
// Optional feature macro: FLEX_UDC_SATURATE_EN. When defined, sat_mode selects
// saturating behaviour at the range ends; when undefined the counter always
// wraps, sat_mode is ignored and sat_flag is tied low.
module flex_udc_counter #(
  parameter int NUM_CNT_BITS = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  flex_udc_counter_if.slave bus
);

  logic [NUM_CNT_BITS-1:0] r_count;
  logic                    r_wrap;
`ifdef FLEX_UDC_SATURATE_EN
  logic                    r_sat;
  logic                    w_step_sat;
`endif

  // One extra bit so the unsigned compares never see an overflowed operand.
  logic [NUM_CNT_BITS:0]   w_cnt_x;
  logic [NUM_CNT_BITS:0]   w_rv_x;
  logic [NUM_CNT_BITS:0]   w_lv_x;
  logic [NUM_CNT_BITS-1:0] w_load_cnt;
  logic [NUM_CNT_BITS-1:0] w_step_cnt;
  logic                    w_step_wrap;

  assign w_cnt_x = {1'b0, r_count};
  assign w_rv_x  = {1'b0, bus.rollover_val};
  assign w_lv_x  = {1'b0, bus.load_val};

  // Loaded value is clamped into the current range.
  assign w_load_cnt = (w_lv_x > w_rv_x) ? bus.rollover_val : bus.load_val;

  // Result of one enabled step, including the wrap/saturate event it causes.
  always_comb begin
    w_step_cnt  = r_count;
    w_step_wrap = 1'b0;
`ifdef FLEX_UDC_SATURATE_EN
    w_step_sat  = 1'b0;
`endif
    if (bus.up_dn) begin
      if (w_cnt_x < w_rv_x) begin
        w_step_cnt = r_count + NUM_CNT_BITS'(1);
      end
`ifdef FLEX_UDC_SATURATE_EN
      else if (bus.sat_mode) begin
        w_step_cnt = bus.rollover_val;
        w_step_sat = 1'b1;
      end
`endif
      else begin
        w_step_cnt  = '0;
        w_step_wrap = 1'b1;
      end
    end else begin
      if (w_cnt_x > w_rv_x) begin
        // Range shrank below the count: snap to the new top, not a wrap.
        w_step_cnt = bus.rollover_val;
      end else if (r_count != '0) begin
        w_step_cnt = r_count - NUM_CNT_BITS'(1);
      end
`ifdef FLEX_UDC_SATURATE_EN
      else if (bus.sat_mode) begin
        w_step_cnt = '0;
        w_step_sat = 1'b1;
      end
`endif
      else begin
        w_step_cnt  = bus.rollover_val;
        w_step_wrap = 1'b1;
      end
    end
  end

  // Count and event flags, resolved by reset > clear > load > step > hold.
  always_ff @(posedge clk) begin
    if (!n_rst || bus.clear) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (bus.load) begin
      r_count <= w_load_cnt;
      r_wrap  <= 1'b0;
    end else if (bus.count_enable) begin
      r_count <= w_step_cnt;
      r_wrap  <= w_step_wrap;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

`ifdef FLEX_UDC_SATURATE_EN
  // Saturation pulse follows the same priority as the count.
  always_ff @(posedge clk) begin
    if (!n_rst || bus.clear || bus.load || !bus.count_enable) begin
      r_sat <= 1'b0;
    end else begin
      r_sat <= w_step_sat;
    end
  end
  assign bus.sat_flag = r_sat;
`else
  assign bus.sat_flag = 1'b0;
`endif

  assign bus.count_out = r_count;
  assign bus.wrap_flag = r_wrap;
  assign bus.at_max    = (w_cnt_x >= w_rv_x);
  assign bus.at_min    = (r_count == '0);

endmodule
